// File: rtl/conv3x3_pe_if.sv
// Window, coefficient-write and result signals of the 3x3 convolution PE.
interface conv3x3_pe_if;
    logic [7:0]  p00, p01, p02, p10, p11, p12, p20, p21, p22;
    logic        window_valid;
    logic        w_load;
    logic [3:0]  w_idx;
    logic [7:0]  w_data;
    logic [7:0]  out_pixel;
    logic        out_valid;
    logic [15:0] out_count;

    modport master (
        output p00, p01, p02, p10, p11, p12, p20, p21, p22,
        output window_valid, w_load, w_idx, w_data,
        input  out_pixel, out_valid, out_count
    );

    modport slave (
        input  p00, p01, p02, p10, p11, p12, p20, p21, p22,
        input  window_valid, w_load, w_idx, w_data,
        output out_pixel, out_valid, out_count
    );
endinterface

// File: rtl/conv3x3_pe.sv
// 3x3 convolution PE, 3-cycle latency, no backpressure (one window per cycle).
// CONV3X3_PE_RELU_EN selects a [0,255] clamp instead of signed [-128,127] saturation.
module conv3x3_pe #(
    parameter int SHIFT = 4,
    parameter int ACC_W = 21
) (
    input  logic         clk,
    input  logic         rst,
    conv3x3_pe_if.slave  s_if
);

`ifdef CONV3X3_PE_RELU_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(255);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(0);
`else
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-128);
`endif

    logic [7:0]               pix [0:8];
    logic signed [7:0]        k_q [0:9];
    logic signed [16:0]       prod_q [0:8];
    logic signed [7:0]        bias1_q;
    logic                     v1_q;
    logic signed [ACC_W-1:0]  acc_d, acc_q;
    logic                     v2_q;
    logic signed [ACC_W-1:0]  shifted;
    logic [7:0]               sat_d;
    logic [7:0]               pix_q;
    logic                     v3_q;
    logic [15:0]              cnt_q;

    assign pix[0] = s_if.p00;
    assign pix[1] = s_if.p01;
    assign pix[2] = s_if.p02;
    assign pix[3] = s_if.p10;
    assign pix[4] = s_if.p11;
    assign pix[5] = s_if.p12;
    assign pix[6] = s_if.p20;
    assign pix[7] = s_if.p21;
    assign pix[8] = s_if.p22;

    // Index 9 is the bias; reset leaves an identity kernel (centre = 1.0).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 10; i++) k_q[i] <= '0;
            k_q[4] <= 8'(1 << SHIFT);
        end else if (s_if.w_load && s_if.w_idx <= 4'd9) begin
            k_q[s_if.w_idx] <= s_if.w_data;
        end
    end

    // Bias travels with the products so later writes cannot touch in-flight data.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
        end else begin
            v1_q <= s_if.window_valid;
            if (s_if.window_valid) begin
                for (int i = 0; i < 9; i++)
                    prod_q[i] <= 17'($signed({1'b0, pix[i]})) * 17'(k_q[i]);
                bias1_q <= k_q[9];
            end
        end
    end

    always_comb begin
        acc_d = {{(ACC_W-8){bias1_q[7]}}, bias1_q};
        for (int i = 0; i < 9; i++)
            acc_d = acc_d + {{(ACC_W-17){prod_q[i][16]}}, prod_q[i]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q <= 1'b0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) acc_q <= acc_d;
        end
    end

    always_comb begin
        shifted = acc_q >>> SHIFT;
        sat_d   = shifted[7:0];
        if (shifted > SAT_MAX)      sat_d = SAT_MAX[7:0];
        else if (shifted < SAT_MIN) sat_d = SAT_MIN[7:0];
    end

    // Count advances on the edge that raises out_valid, so it includes the current pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            v3_q  <= 1'b0;
            pix_q <= '0;
            cnt_q <= '0;
        end else begin
            v3_q <= v2_q;
            if (v2_q) begin
                pix_q <= sat_d;
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign s_if.out_pixel = pix_q;
    assign s_if.out_valid = v3_q;
    assign s_if.out_count = cnt_q;

endmodule

// File: tb/tb_conv3x3_pe.sv
// Scoreboarded random bench for conv3x3_pe against an integer reference model.
module tb_conv3x3_pe;
    localparam int SHIFT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv3x3_pe_if bus();
    conv3x3_pe #(.SHIFT(SHIFT), .ACC_W(21)) dut (.clk(clk), .rst(rst), .s_if(bus));

    logic [7:0] win [0:8];
    assign bus.p00 = win[0];
    assign bus.p01 = win[1];
    assign bus.p02 = win[2];
    assign bus.p10 = win[3];
    assign bus.p11 = win[4];
    assign bus.p12 = win[5];
    assign bus.p20 = win[6];
    assign bus.p21 = win[7];
    assign bus.p22 = win[8];

    typedef struct {
        logic [7:0] pix;
        int         due;
    } exp_t;

    exp_t       exp_q [$];
    int         km [0:9];
    int         cnt_m;
    logic [7:0] last_pix;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] ref_out();
        int s = km[9];
        for (int i = 0; i < 9; i++) s += int'(win[i]) * km[i];
        s = s >>> SHIFT;
`ifdef CONV3X3_PE_RELU_EN
        if (s < 0) s = 0;
        else if (s > 255) s = 255;
`else
        if (s < -128) s = -128;
        else if (s > 127) s = 127;
`endif
        return 8'(s);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 10; i++) km[i] = 0;
        km[4] = 1 << SHIFT;
        cnt_m = 0;
        last_pix = 8'd0;
        exp_q.delete();
    endtask

    task automatic rand_win();
        for (int j = 0; j < 9; j++) win[j] = 8'($urandom);
    endtask

    // Expectation uses the coefficients in force before this cycle's write.
    task automatic step(input bit wv, input bit wl, input logic [3:0] idx, input logic [7:0] dat);
        bus.window_valid = wv;
        bus.w_load = wl;
        bus.w_idx = idx;
        bus.w_data = dat;
        if (!rst) begin
            if (wv) exp_q.push_back('{ref_out(), cyc + 3});
            if (wl && idx <= 4'd9) km[idx] = int'($signed(dat));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'd0, 8'd0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        reset_model();
        for (int i = 0; i < n; i++) begin
            rand_win();
            bus.window_valid = 1'b1;
            bus.w_load = 1'b1;
            bus.w_idx = 4'(i % 10);
            bus.w_data = 8'($urandom);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        bus.window_valid = 1'b0;
        bus.w_load = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            idle();
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d outputs outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        idle();
        idle();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.out_valid) begin
                cnt_m++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid: got pixel %0d, required no output", bus.out_pixel);
                    last_pix = bus.out_pixel;
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pixel", 32'(bus.out_pixel), 32'(e.pix));
                    chk("latency_cycle", cyc, e.due);
                    last_pix = e.pix;
                end
                chk("out_count", 32'(bus.out_count), 32'(cnt_m[15:0]));
            end else begin
                chk("hold_pixel", 32'(bus.out_pixel), 32'(last_pix));
                chk("idle_count", 32'(bus.out_count), 32'(cnt_m[15:0]));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.window_valid = 1'b0;
        bus.w_load = 1'b0;
        bus.w_idx = 4'd0;
        bus.w_data = 8'd0;
        rand_win();
        do_reset(3);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_out_pixel", 32'(bus.out_pixel), 32'd0);
        chk("reset_out_count", 32'(bus.out_count), 32'd0);

        // Identity kernel straight out of reset.
        for (int i = 0; i < 9; i++) win[i] = 8'hFF;
        win[4] = 8'd100;
        step(1'b1, 1'b0, 4'd0, 8'd0);
        drain();
        chk("count_after_first", 32'(bus.out_count), 32'd1);

        // All-ones kernel on a saturated window.
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 4'(i), 8'd1);
        step(1'b0, 1'b1, 4'd9, 8'd0);
        for (int i = 0; i < 9; i++) win[i] = 8'd255;
        step(1'b1, 1'b0, 4'd0, 8'd0);
        drain();

        // All-minus-ones kernel.
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 4'(i), 8'hFF);
        step(1'b1, 1'b0, 4'd0, 8'd0);
        drain();

        // Ten back-to-back windows under the identity kernel.
        do_reset(2);
        for (int v = 0; v < 10; v++) begin
            rand_win();
            win[4] = 8'(v);
            step(1'b1, 1'b0, 4'd0, 8'd0);
        end
        drain();
        chk("count_after_ten", 32'(bus.out_count), 32'd10);

        // Write coincident with a window, then an ignored out-of-range index.
        for (int i = 0; i < 9; i++) win[i] = 8'd0;
        win[4] = 8'd10;
        step(1'b1, 1'b1, 4'd4, 8'd32);
        step(1'b1, 1'b0, 4'd0, 8'd0);
        step(1'b1, 1'b1, 4'd12, 8'd99);
        step(1'b1, 1'b0, 4'd0, 8'd0);
        drain();

        // Random windows interleaved with random coefficient writes.
        for (int n = 0; n < 400; n++) begin
            rand_win();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                 4'($urandom_range(0, 15)), 8'($urandom));
        end
        drain();

        // Reset while two windows are in flight.
        rand_win();
        step(1'b1, 1'b0, 4'd0, 8'd0);
        step(1'b1, 1'b0, 4'd0, 8'd0);
        do_reset(2);
        drain();
        chk("count_after_flush", 32'(bus.out_count), 32'd0);
        rand_win();
        step(1'b1, 1'b0, 4'd0, 8'd0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv3x3_pe.md
CONV3X3_PE -- requirements
Module: conv3x3_pe

Interface
REQ-001 Parameter SHIFT, default 4, meaning arithmetic right-shift applied to the accumulator before output saturation (fixed-point weight scale 2^SHIFT).
REQ-002 Parameter ACC_W, default 21, meaning accumulator width in bits; SHALL be at least 21.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 p00..p22  input  8 each  unsigned 3x3 window pixels from the upstream line buffer; row-major, p00 = top-left, p11 = centre.
REQ-006 window_valid  input  1  window p00..p22 is valid this cycle.
REQ-007 w_load  input  1  coefficient write strobe.
REQ-008 w_idx  input  4  coefficient index: 0..8 = kernel weight k0..k8 (row-major, matching p00..p22); 9 = bias.
REQ-009 w_data  input  8  signed two's-complement coefficient value.
REQ-010 out_pixel  output  8  convolution result.
REQ-011 out_valid  output  1  out_pixel valid this cycle.
REQ-012 out_count  output  16  number of out_valid pulses since reset; wraps modulo 2^16.

Function
REQ-013 Pipeline: three stages, no stall; every window_valid cycle SHALL produce exactly one out_valid cycle 3 clocks later, in order. Back-to-back windows SHALL be accepted every cycle.
REQ-014 Stage 1: register nine products pij * kn, with the pixel zero-extended to 9-bit signed; each product is 17-bit signed.
REQ-015 Stage 2: register the sum of the nine products plus the sign-extended bias as an ACC_W-bit signed value. This sum SHALL NOT overflow.
REQ-016 Stage 3: shift the accumulator right arithmetically by SHIFT (floor rounding), then saturate per REQ-024/REQ-025, and register the result as out_pixel.
REQ-017 Each stage SHALL carry its own valid bit; out_valid is the stage-3 valid.
REQ-018 out_pixel SHALL hold its last value when out_valid = 0.
REQ-019 Coefficient write: on a cycle with w_load = 1, the coefficient at w_idx SHALL take w_data at that clock edge. w_idx 10..15 SHALL be ignored with no effect.
REQ-020 A window accepted in the same cycle as a coefficient write SHALL use the old coefficient; windows accepted in later cycles SHALL use the new one.
REQ-021 Products already in the pipeline SHALL NOT be affected by later coefficient writes.
REQ-022 out_count SHALL increment by 1 in every cycle where out_valid = 1, and SHALL wrap from 65535 to 0.

Reset
REQ-023 On rst = 1:
  - all pipeline valid bits, out_valid, out_pixel and out_count SHALL clear to 0;
  - k4 SHALL load 2^SHIFT (16 at default); all other weights and the bias SHALL load 0 (identity kernel);
  - windows in flight SHALL be discarded, and no out_valid SHALL appear for them after rst deasserts;
  - window_valid and w_load SHALL be ignored while rst = 1.

Configuration
REQ-024 With CONV3X3_PE_RELU_EN defined: the shifted result SHALL be clamped to [0, 255]; out_pixel is unsigned.
REQ-025 Without CONV3X3_PE_RELU_EN: the shifted result SHALL be saturated to [-128, 127]; out_pixel is two's complement.

Verification
REQ-026 After reset, no coefficient writes, one window with p11 = 100 and all other pixels 0xFF -> out_valid exactly 3 cycles later, out_pixel = 100, out_count = 1.
REQ-027 Load k0..k8 = 1, bias = 0, then one window with all pixels 255 -> sum 2295, shifted 143 -> RELU_EN: out_pixel = 143; no RELU_EN: out_pixel = 127.
REQ-028 Load k0..k8 = -1, then one window with all pixels 255 -> shifted -144 -> RELU_EN: out_pixel = 0; no RELU_EN: out_pixel = 0x80.
REQ-029 Ten consecutive window_valid cycles with p11 = 0..9 under the identity kernel -> ten consecutive out_valid cycles, out_pixel = 0..9 in order, out_count = 10.
REQ-030 w_load with w_idx = 4, w_data = 32 in the same cycle as a window with p11 = 10, then the same window on the next cycle -> outputs 10 then 20; a write with w_idx = 12 -> no coefficient change.
REQ-031 Assert rst one cycle after issuing two windows -> no out_valid for either window; out_count = 0; identity kernel restored.
